monitor_semaforo: RTL

Passive protocol checker at the output side of the traffic-light controller. It samples the two light-state buses A and B every clock and enforces a fixed set of rules:
- code legality
- no conflicting rights of way
- the verde→amarelo→vermelho→verde order
- amarelo and vermelho durations

It latches the first violation it sees and counts completed A cycles. It sits beside the controller in every bench and in the top-level build as a safety net. It never drives the controller.

---
 rtl/semaforo_pkg.sv | 53 +++++
 rtl/monitor_semaforo_if.sv | 38 +++
 rtl/rastreador_luz.sv | 75 +++++++
 rtl/monitor_semaforo.sv | 110 +++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// ============================================================================
// Module   : semaforo_pkg
// Desc     : Shared light codes, tracker state enum and monitor error codes.
// Revision : 1.0
// ============================================================================
`default_nettype none

package semaforo_pkg;

  // One-hot light codes as seen on the controller output buses
  localparam logic [2:0] VERDE_OH    = 3'b001;
  localparam logic [2:0] AMARELO_OH  = 3'b010;
  localparam logic [2:0] VERMELHO_OH = 3'b100;

  typedef enum logic [1:0] {
    SEM_VERDE    = 2'd0,
    SEM_AMARELO  = 2'd1,
    SEM_VERMELHO = 2'd2
  } sem_estado_t;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_ILEGAL    = 3'd1;
  localparam logic [2:0] ERR_CONFLITO  = 3'd2;
  localparam logic [2:0] ERR_SEQUENCIA = 3'd3;
  localparam logic [2:0] ERR_DURACAO   = 3'd4;

  localparam logic FONTE_A = 1'b0;
  localparam logic FONTE_B = 1'b1;

  function automatic logic eh_legal(input logic [2:0] oh);
    return (oh == VERDE_OH) || (oh == AMARELO_OH) || (oh == VERMELHO_OH);
  endfunction

  // Only meaningful for legal codes; anything else maps to vermelho
  function automatic sem_estado_t decodificar(input logic [2:0] oh);
    case (oh)
      VERDE_OH:   return SEM_VERDE;
      AMARELO_OH: return SEM_AMARELO;
      default:    return SEM_VERMELHO;
    endcase
  endfunction

  function automatic sem_estado_t sucessor(input sem_estado_t e);
    case (e)
      SEM_VERDE:   return SEM_AMARELO;
      SEM_AMARELO: return SEM_VERMELHO;
      default:     return SEM_VERDE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/monitor_semaforo_if.sv
// ============================================================================
// Module   : monitor_semaforo_if
// Desc     : Light-state buses observed by the monitor plus its status outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface monitor_semaforo_if;

  logic [2:0] A;
  logic [2:0] B;
  logic       erro;
  logic [2:0] cod_erro;
  logic       fonte;
  logic [7:0] ciclos_a;

  // master: whoever drives the light buses and reads the monitor status
  modport master (
    output A,
    output B,
    input  erro,
    input  cod_erro,
    input  fonte,
    input  ciclos_a
  );

  modport slave (
    input  A,
    input  B,
    output erro,
    output cod_erro,
    output fonte,
    output ciclos_a
  );

endinterface

`default_nettype wire

// File: rtl/rastreador_luz.sv
// ============================================================================
// Module   : rastreador_luz
// Desc     : Per-light tracker: legality, order and duration checks for one bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rastreador_luz
  import semaforo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sample,
  input  logic [7:0] AMARELO,
  input  logic [7:0] VERMELHO_MIN,
  output logic       legal,
  output logic       err_seq,
  output logic       err_dur,
  output logic       vermelho_para_verde
);

  sem_estado_t r_estado;
  logic [7:0]  r_cont;
  logic        r_valido;

  sem_estado_t w_atual;
  logic        w_mudou;
  logic        w_checa;

  always_comb begin
    legal   = eh_legal(sample);
    w_atual = decodificar(sample);
    // The first legal sample after reset is only a baseline
    w_checa = legal && r_valido;
    w_mudou = w_checa && (w_atual != r_estado);

    err_seq = w_mudou && (w_atual != sucessor(r_estado));

    err_dur = 1'b0;
    if (w_mudou && (r_estado == SEM_AMARELO) && (r_cont != AMARELO)) begin
      err_dur = 1'b1;
    end
    // Stuck amarelo: flag the sample that takes the run to AMARELO+1
    if (w_checa && !w_mudou && (r_estado == SEM_AMARELO) &&
        (r_cont == AMARELO) && (r_cont != 8'hFF)) begin
      err_dur = 1'b1;
    end
    if (w_mudou && (r_estado == SEM_VERMELHO) && (w_atual == SEM_VERDE) &&
        (r_cont < VERMELHO_MIN)) begin
      err_dur = 1'b1;
    end

    vermelho_para_verde = w_mudou && (r_estado == SEM_VERMELHO) &&
                          (w_atual == SEM_VERDE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= SEM_VERDE;
      r_cont   <= 8'd0;
      r_valido <= 1'b0;
    end else if (legal) begin
      if (!r_valido || (w_atual != r_estado)) begin
        r_estado <= w_atual;
        r_cont   <= 8'd1;
        r_valido <= 1'b1;
      end else if (r_cont != 8'hFF) begin
        r_cont <= r_cont + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/monitor_semaforo.sv
// ============================================================================
// Module   : monitor_semaforo
// Desc     : Passive traffic-light protocol checker; latches the first violation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module monitor_semaforo
  import semaforo_pkg::*;
#(
  parameter logic [7:0] AMARELO      = 8'd3,
  parameter logic [7:0] VERMELHO_MIN = 8'd2
) (
  input  logic               clk,
  input  logic               rst,
  monitor_semaforo_if.slave  bus
);

  logic w_legal_a, w_seq_a, w_dur_a, w_vpv_a;
  logic w_legal_b, w_seq_b, w_dur_b, w_vpv_b;
  logic w_conflito;
  logic w_viol;
  logic [2:0] w_cod;
  logic w_fonte;

  logic       r_erro;
  logic [2:0] r_cod_erro;
  logic       r_fonte;
  logic [7:0] r_ciclos_a;

  rastreador_luz u_luz_a (
    .clk                 (clk),
    .rst                 (rst),
    .sample              (bus.A),
    .AMARELO             (AMARELO),
    .VERMELHO_MIN        (VERMELHO_MIN),
    .legal               (w_legal_a),
    .err_seq             (w_seq_a),
    .err_dur             (w_dur_a),
    .vermelho_para_verde (w_vpv_a)
  );

  rastreador_luz u_luz_b (
    .clk                 (clk),
    .rst                 (rst),
    .sample              (bus.B),
    .AMARELO             (AMARELO),
    .VERMELHO_MIN        (VERMELHO_MIN),
    .legal               (w_legal_b),
    .err_seq             (w_seq_b),
    .err_dur             (w_dur_b),
    .vermelho_para_verde (w_vpv_b)
  );

  always_comb begin
    w_conflito = w_legal_a && w_legal_b &&
                 (bus.A != VERMELHO_OH) && (bus.B != VERMELHO_OH);

    // Code order first, then A before B inside the same code
    w_viol  = 1'b1;
    w_cod   = ERR_NONE;
    w_fonte = FONTE_A;
    if (!w_legal_a) begin
      w_cod = ERR_ILEGAL;
    end else if (!w_legal_b) begin
      w_cod   = ERR_ILEGAL;
      w_fonte = FONTE_B;
    end else if (w_conflito) begin
      w_cod = ERR_CONFLITO;
    end else if (w_seq_a) begin
      w_cod = ERR_SEQUENCIA;
    end else if (w_seq_b) begin
      w_cod   = ERR_SEQUENCIA;
      w_fonte = FONTE_B;
    end else if (w_dur_a) begin
      w_cod = ERR_DURACAO;
    end else if (w_dur_b) begin
      w_cod   = ERR_DURACAO;
      w_fonte = FONTE_B;
    end else begin
      w_viol = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_erro     <= 1'b0;
      r_cod_erro <= ERR_NONE;
      r_fonte    <= FONTE_A;
      r_ciclos_a <= 8'd0;
    end else begin
      if (!r_erro && w_viol) begin
        r_erro     <= 1'b1;
        r_cod_erro <= w_cod;
        r_fonte    <= w_fonte;
      end
      if (w_vpv_a) begin
        r_ciclos_a <= r_ciclos_a + 8'd1;
      end
    end
  end

  assign bus.erro     = r_erro;
  assign bus.cod_erro = r_cod_erro;
  assign bus.fonte    = r_fonte;
  assign bus.ciclos_a = r_ciclos_a;

endmodule

`default_nettype wire
